// File: rtl/fiber_pkg.sv
// Shared fibre-link definitions: slot timing, frame field widths, receiver FSM states, checksum.
// Used by both the transmitter and the receiver so that the two ends agree on the frame layout.
package fiber_pkg;

    localparam int COUNT_4MHZ = 9;
    localparam int VOLT_BITS  = 12;
    localparam int INFO_BITS  = 14;
    localparam int CHK_BITS   = 7;
    localparam int FRAME_BITS = VOLT_BITS + INFO_BITS + CHK_BITS;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CHECK
    } rx_state_e;

    // Fields in shift-register order: volt arrives first, so it sits in the LSBs.
    typedef struct packed {
        logic [CHK_BITS-1:0]  chk;
        logic [INFO_BITS-1:0] info;
        logic [VOLT_BITS-1:0] volt;
    } frame_t;

    function automatic logic [CHK_BITS-1:0] fiber_checksum(
        input logic [VOLT_BITS-1:0] volt,
        input logic [INFO_BITS-1:0] info
    );
        fiber_checksum = 7'(volt[3:0]) + 7'(volt[7:4]) + 7'(volt[11:8])
                       + 7'(info[3:0]) + 7'(info[7:4]) + 7'(info[11:8])
                       + 7'(info[13:12]);
    endfunction

endpackage

// File: rtl/fiber_rx_sampler.sv
// Line front end: 2-FF synchronizer, bit-slot counter and bit sampler producing rx and a sample strobe.
// FIBER_RX_MAJORITY_EN selects a 2-of-3 vote over counts 3/4/5 instead of a single count-4 sample.
module fiber_rx_sampler
    import fiber_pkg::*;
#(
    parameter int COUNT_4MHZ = fiber_pkg::COUNT_4MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    input  logic cnt_clr,
    output logic rx,
    output logic smp_bit,
    output logic smp_stb
);

    localparam int CW = $clog2(COUNT_4MHZ + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_4MHZ);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign rx = ~sync_q[1];

    always_comb begin
        sync_d = {sync_q[0], line_i};
        if (cnt_clr || cnt_q == CNT_LAST) cnt_d = '0;
        else                              cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef FIBER_RX_MAJORITY_EN
    logic s3_q, s3_d, s4_q, s4_d;

    always_comb begin
        s3_d    = (cnt_q == CW'(3)) ? rx : s3_q;
        s4_d    = (cnt_q == CW'(4)) ? rx : s4_q;
        smp_stb = (cnt_q == CW'(5));
        smp_bit = (s3_q & s4_q) | (s3_q & rx) | (s4_q & rx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_q <= 1'b0;
            s4_q <= 1'b0;
        end else begin
            s3_q <= s3_d;
            s4_q <= s4_d;
        end
    end
`else
    always_comb begin
        smp_stb = (cnt_q == CW'(4));
        smp_bit = rx;
    end
`endif

endmodule

// File: rtl/fiber_rx.sv
// Fibre status-frame receiver: hunts for an idle guard, frames start/data bits, checks the sum, tracks link health.
// Build option FIBER_RX_MAJORITY_EN selects the majority-vote bit sampler.
module fiber_rx #(
    parameter int COUNT_4MHZ   = fiber_pkg::COUNT_4MHZ,
    parameter int GUARD_BITS   = 8,
    parameter int LINK_TIMEOUT = 3200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        COMM_R,
    output logic [11:0] udc_volt,
    output logic [11:0] err_info,
    output logic        ModuRun,
    output logic        BypOk,
    output logic        frame_ok,
    output logic        chk_err,
    output logic        link_ok
);

    import fiber_pkg::*;

    localparam int GUARD_CLKS = GUARD_BITS * (COUNT_4MHZ + 1);
    localparam int HW         = $clog2(GUARD_CLKS + 1);
    localparam int TW         = $clog2(LINK_TIMEOUT + 1);

    rx_state_e state_q, state_d;

    logic                  rx, smp_bit, smp_stb;
    logic                  cnt_clr, shift_en, check;
    logic                  rx_prev_q, rx_prev_d;
    logic [HW-1:0]         hunt_q, hunt_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [VOLT_BITS-1:0]  volt_q, volt_d;
    logic [INFO_BITS-1:0]  info_q, info_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  chk_err_q, chk_err_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    frame_t                frame;
    logic                  match;

    fiber_rx_sampler #(.COUNT_4MHZ(COUNT_4MHZ)) u_sampler (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (COMM_R),
        .cnt_clr (cnt_clr),
        .rx      (rx),
        .smp_bit (smp_bit),
        .smp_stb (smp_stb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT:  if (rx && hunt_q == HW'(GUARD_CLKS - 1)) state_d = ST_IDLE;
            ST_IDLE:  if (rx_prev_q && !rx) state_d = ST_START;
            ST_START: if (smp_stb) state_d = smp_bit ? ST_IDLE : ST_DATA;
            ST_DATA:  if (smp_stb && bit_cnt_q == 6'(FRAME_BITS - 1)) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_HUNT;
            default:  state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        cnt_clr  = (state_q == ST_IDLE) && rx_prev_q && !rx;
        shift_en = (state_q == ST_DATA) && smp_stb;
        check    = (state_q == ST_CHECK);
    end

    // Slot timing is re-anchored on every start edge, so only the frame's own edge matters.
    always_comb begin
        rx_prev_d = rx;
        hunt_d    = (state_q == ST_HUNT && rx) ? hunt_q + 1'b1 : '0;
        bit_cnt_d = (state_q == ST_START) ? '0 : (shift_en ? bit_cnt_q + 1'b1 : bit_cnt_q);
        shreg_d   = shift_en ? {smp_bit, shreg_q[FRAME_BITS-1:1]} : shreg_q;

        frame      = frame_t'(shreg_q);
        match      = (fiber_checksum(frame.volt, frame.info) == frame.chk);
        frame_ok_d = check && match;
        chk_err_d  = check && !match;
        volt_d     = frame_ok_d ? frame.volt : volt_q;
        info_d     = frame_ok_d ? frame.info : info_q;

        if (frame_ok_d)                     tmr_d = '0;
        else if (tmr_q == TW'(LINK_TIMEOUT)) tmr_d = tmr_q;
        else                                tmr_d = tmr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_prev_q  <= 1'b0;
            hunt_q     <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            volt_q     <= '0;
            info_q     <= '0;
            frame_ok_q <= 1'b0;
            chk_err_q  <= 1'b0;
            tmr_q      <= TW'(LINK_TIMEOUT);
        end else begin
            rx_prev_q  <= rx_prev_d;
            hunt_q     <= hunt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            volt_q     <= volt_d;
            info_q     <= info_d;
            frame_ok_q <= frame_ok_d;
            chk_err_q  <= chk_err_d;
            tmr_q      <= tmr_d;
        end
    end

    assign udc_volt = volt_q;
    assign err_info = info_q[11:0];
    assign ModuRun  = info_q[12];
    assign BypOk    = info_q[13];
    assign frame_ok = frame_ok_q;
    assign chk_err  = chk_err_q;
    assign link_ok  = (tmr_q < TW'(LINK_TIMEOUT));

endmodule
